soc_simple_pll_rst_seq: RTL and testbench
=========================================

SOC_SIMPLE_PLL_RST_SEQ -- requirements
Module: soc_simple_pll_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset attempt (minimum 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: number of cycles to wait for lock before retrying (minimum 2).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of cycles lock must stay continuously high before system reset is released (minimum 2).
REQ-004 SHALL have port clk, input, 1 bit: free-running 50 MHz reference clock, the same clock that feeds the PLL refclk.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low board reset; it is the only reset and there is one clock.
REQ-006 SHALL have port pll_locked, input, 1 bit: PLL locked output, asynchronous to clk.
REQ-007 SHALL have port clr_counts, input, 1 bit: synchronous single-cycle pulse that clears both fault counters.
REQ-008 SHALL have port pll_rst, output, 1 bit: active-high reset driven to the PLL rst input.
REQ-009 SHALL have port sys_rst_n, output, 1 bit: active-low reset request for downstream domains; those domains synchronize its deassertion locally.
REQ-010 SHALL have port seq_state, output, 2 bits: current sequencer state code.
REQ-011 SHALL have port retry_cnt, output, 8 bits: count of lock timeouts, saturating.
REQ-012 SHALL have port lock_loss_cnt, output, 8 bits: count of lock losses while in RUN, saturating.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; its output locked_s SHALL be the only lock signal used, giving 2 cycles of latency.
REQ-014 The FSM SHALL have the states PLL_RST=0, WAIT_LOCK=1, STABLE=2 and RUN=3, encoded as those values on seq_state.
REQ-015 A single shared cycle counter SHALL clear to 0 on every state entry and increment by 1 every cycle otherwise; it SHALL be sized as clog2 of the largest parameter.
REQ-016 PLL_RST SHALL move to WAIT_LOCK when cnt equals PLL_RST_CYCLES-1, so pll_rst is high for exactly PLL_RST_CYCLES cycles.
REQ-017 WAIT_LOCK SHALL move to STABLE when locked_s is 1; otherwise, when cnt equals LOCK_TIMEOUT_CYCLES-1, it SHALL move to PLL_RST and increment retry_cnt.
REQ-018 STABLE SHALL move back to WAIT_LOCK when locked_s is 0; otherwise, when cnt equals LOCK_STABLE_CYCLES-1, it SHALL move to RUN.
REQ-019 RUN SHALL move to PLL_RST and increment lock_loss_cnt when locked_s is 0.
REQ-020 When lock loss and counter expiry occur in the same cycle, lock loss SHALL take priority.
REQ-021 pll_rst SHALL equal (state==PLL_RST) and sys_rst_n SHALL equal (state==RUN), both driven directly from flops so the outputs are glitch-free.
REQ-022 The fault counters SHALL saturate at 255 and never wrap.
REQ-023 When clr_counts coincides with an increment, the clear SHALL win and the counter SHALL read 0 on the next cycle.
REQ-024 Retries SHALL be unlimited; the sequencer SHALL never enter a terminal fault state.

Reset
REQ-025 Assertion of reset_n low SHALL asynchronously force: state PLL_RST, cnt 0, pll_rst 1, sys_rst_n 0, both synchronizer flops 0, retry_cnt 0 and lock_loss_cnt 0.
REQ-026 After reset_n deasserts, the FSM SHALL begin counting in PLL_RST on the first clk edge.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence immediately, with no partial-state carry-over.

Structure
REQ-028 Package soc_simple_rst_pkg SHALL hold the state enum (2 bits), the default parameter constants and the counter width.
REQ-029 The synchronizer SHALL be the sub-module soc_simple_bit_sync (2 flops, async active-low reset, reset value parameterized).
REQ-030 All sequencing logic SHALL reside in soc_simple_pll_rst_seq, with no other sub-modules.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8)
REQ-031 Power-up: release reset_n with pll_locked=1 constant -> pll_rst high for cycles 1-4, STABLE entered by cycle 7, sys_rst_n rises by cycle 15, retry_cnt=0.
REQ-032 No lock: hold pll_locked=0 -> pll_rst pulses of 4 cycles every 36 cycles; retry_cnt reaches 3 after 3 timeouts and saturates at 255 when forced.
REQ-033 Lock glitch in STABLE: drop pll_locked for 3 cycles at STABLE cnt=5 -> return to WAIT_LOCK, cnt restarts, sys_rst_n stays 0, RUN is reached 8 cycles after lock is stable.
REQ-034 Lock loss in RUN: drop pll_locked -> sys_rst_n falls 3 cycles later (2 synchronizer cycles + 1 FSM cycle), pll_rst rises in that same cycle, lock_loss_cnt becomes 1.
REQ-035 Simultaneous events: clr_counts coincident with a timeout -> retry_cnt reads 0; lock loss at STABLE cnt=7 -> WAIT_LOCK, not RUN.
REQ-036 Async reset mid-RUN: assert reset_n between clk edges -> sys_rst_n falls and pll_rst rises without a clk edge, and all counters read 0.

Source files
------------

// File: rtl/soc_simple_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package soc_simple_rst_pkg;

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } seq_state_e;

  localparam int unsigned DefPllRstCycles      = 16;
  localparam int unsigned DefLockTimeoutCycles = 65536;
  localparam int unsigned DefLockStableCycles  = 1024;

  // Counter only has to reach (largest duration - 1).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  localparam int unsigned DefCntWidth =
      cnt_width(DefPllRstCycles, DefLockTimeoutCycles, DefLockStableCycles);

endpackage

// File: rtl/soc_simple_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level signal.
module soc_simple_bit_sync #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/soc_simple_pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the system reset; retries forever and counts timeouts and lock losses.
module soc_simple_pll_rst_seq
  import soc_simple_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
  parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       clr_counts,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [1:0] seq_state,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CntW =
      cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      retry_q, retry_d, loss_q, loss_d;
  logic            pll_rst_q, sys_rst_n_q;
  logic            locked_s, timeout, lock_loss;

  soc_simple_bit_sync #(
    .RESET_VALUE(1'b0)
  ) u_lock_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (pll_locked),
    .q      (locked_s)
  );

  // Lock loss is tested before counter expiry so it always wins.
  always_comb begin
    state_d   = state_q;
    timeout   = 1'b0;
    lock_loss = 1'b0;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == PllRstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StPllRst;
          timeout = 1'b1;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d   = StPllRst;
          lock_loss = 1'b1;
        end
      end
      default: state_d = StPllRst;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    retry_d = retry_q;
    if (clr_counts) begin
      retry_d = '0;
    end else if (timeout && (retry_q != 8'hff)) begin
      retry_d = retry_q + 8'd1;
    end

    loss_d = loss_q;
    if (clr_counts) begin
      loss_d = '0;
    end else if (lock_loss && (loss_q != 8'hff)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  // Reset outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == StPllRst);
      sys_rst_n_q <= (state_d == StRun);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign seq_state     = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_soc_simple_pll_rst_seq.sv
// Self-checking bench: phase/elapsed-time model plus directed scenario checks.
module tb_soc_simple_pll_rst_seq;

  localparam int PR = 4;
  localparam int TO = 32;
  localparam int ST = 8;

  logic       clk, reset_n, pll_locked, clr_counts;
  logic       pll_rst, sys_rst_n;
  logic [1:0] seq_state;
  logic [7:0] retry_cnt, lock_loss_cnt;

  int tests = 0;
  int fails = 0;
  bit checking = 0;

  soc_simple_pll_rst_seq #(
    .PLL_RST_CYCLES     (PR),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (ST)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .clr_counts   (clr_counts),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .seq_state    (seq_state),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0..3 with time spent in phase; lock seen with two samples of delay.
  int m_ph, m_t, m_retry, m_loss, m_nxt;
  bit lq[$];
  bit m_ls;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 0; m_t = 0; m_retry = 0; m_loss = 0;
      lq = '{1'b0, 1'b0};
    end else begin
      m_ls = lq.pop_front();
      lq.push_back(pll_locked);
      m_nxt = m_ph;
      if (m_ph == 0 && m_t == PR - 1) m_nxt = 1;
      else if (m_ph == 1 && m_ls) m_nxt = 2;
      else if (m_ph == 1 && m_t == TO - 1) begin
        m_nxt = 0;
        if (!clr_counts && m_retry < 255) m_retry++;
      end
      else if (m_ph == 2 && !m_ls) m_nxt = 1;
      else if (m_ph == 2 && m_t == ST - 1) m_nxt = 3;
      else if (m_ph == 3 && !m_ls) begin
        m_nxt = 0;
        if (!clr_counts && m_loss < 255) m_loss++;
      end
      if (clr_counts) begin
        m_retry = 0;
        m_loss  = 0;
      end
      m_t  = (m_nxt != m_ph) ? 0 : m_t + 1;
      m_ph = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_state", int'(seq_state), m_ph);
      chk("cyc_pll_rst", int'(pll_rst), int'(m_ph == 0));
      chk("cyc_sys_rst_n", int'(sys_rst_n), int'(m_ph == 3));
      chk("cyc_retry", int'(retry_cnt), m_retry);
      chk("cyc_loss", int'(lock_loss_cnt), m_loss);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_model(input int ph, input int t, input int budget, input string name);
    int n = 0;
    while (!(m_ph == ph && m_t == t) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL %s: phase %0d/%0d not reached, got %0d/%0d", name, ph, t, m_ph, m_t);
    end
  endtask

  initial begin
    reset_n = 1; pll_locked = 1; clr_counts = 0;
    #1 reset_n = 0;
    cycles(3);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_sys_rst_n", int'(sys_rst_n), 0);
    chk("rst_state", int'(seq_state), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_loss", int'(lock_loss_cnt), 0);
    checking = 1;

    // Power-up with lock held high
    reset_n = 1;
    cycles(3);
    chk("pwr_pll_rst_c3", int'(pll_rst), 1);
    cycles(1);
    chk("pwr_pll_rst_c4", int'(pll_rst), 0);
    chk("pwr_wait_c4", int'(seq_state), 1);
    cycles(1);
    chk("pwr_stable_c5", int'(seq_state), 2);
    cycles(7);
    chk("pwr_sys_c12", int'(sys_rst_n), 0);
    cycles(1);
    chk("pwr_run_c13", int'(seq_state), 3);
    chk("pwr_sys_c13", int'(sys_rst_n), 1);
    chk("pwr_retry", int'(retry_cnt), 0);

    // Lock loss in RUN: three cycles to react
    cycles(2);
    pll_locked = 0;
    cycles(2);
    chk("loss_sys_c2", int'(sys_rst_n), 1);
    cycles(1);
    chk("loss_sys_c3", int'(sys_rst_n), 0);
    chk("loss_pll_rst_c3", int'(pll_rst), 1);
    chk("loss_cnt", int'(lock_loss_cnt), 1);
    pll_locked = 1;

    // Glitch in STABLE at cnt=5, seen at cnt=7: back to WAIT_LOCK, not RUN
    wait_model(2, 5, 100, "glitch_reach");
    pll_locked = 0;
    cycles(2);
    chk("glitch_stable_cnt7", int'(seq_state), 2);
    cycles(1);
    chk("glitch_wait", int'(seq_state), 1);
    chk("glitch_sys", int'(sys_rst_n), 0);
    pll_locked = 1;
    cycles(10);
    chk("glitch_restable", int'(seq_state), 2);
    cycles(1);
    chk("glitch_run", int'(seq_state), 3);
    chk("glitch_run_sys", int'(sys_rst_n), 1);

    // Async reset between edges
    cycles(2);
    #2 reset_n = 0;
    #1;
    chk("arst_sys", int'(sys_rst_n), 0);
    chk("arst_pll_rst", int'(pll_rst), 1);
    chk("arst_state", int'(seq_state), 0);
    chk("arst_retry", int'(retry_cnt), 0);
    chk("arst_loss", int'(lock_loss_cnt), 0);
    @(negedge clk);
    pll_locked = 0;
    cycles(2);

    // No lock: timeouts every 36 cycles
    reset_n = 1;
    cycles(107);
    chk("nolock_retry_107", int'(retry_cnt), 2);
    cycles(1);
    chk("nolock_retry_108", int'(retry_cnt), 3);
    chk("nolock_state_108", int'(seq_state), 0);
    cycles(3);
    chk("nolock_pll_rst_111", int'(pll_rst), 1);
    cycles(1);
    chk("nolock_pll_rst_112", int'(pll_rst), 0);

    // Clear coincident with timeout
    wait_model(1, TO - 1, 100, "clr_reach");
    chk("clr_pre", int'(retry_cnt), 3);
    clr_counts = 1;
    cycles(1);
    clr_counts = 0;
    chk("clr_retry", int'(retry_cnt), 0);
    chk("clr_state", int'(seq_state), 0);

    // Saturation
    for (int i = 0; i < 300 * 36 && m_retry < 255; i++) cycles(1);
    chk("sat_reach", int'(retry_cnt), 255);
    cycles(72);
    chk("sat_hold", int'(retry_cnt), 255);

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
